pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Owns the program counter and sequences next-PC selection for the single-cycle MIPS datapath.
- Adds the sequential parts the combinational datapath muxes lack:
  - a registered PC;
  - stall hold;
  - a kernel/user mode bit (PC[31]);
  - trap entry for illegal ops and external interrupts, with exception-PC writeback to $26 (xp);
  - a level-interrupt acknowledge handshake.
- Sits between control decode and instruction memory.

Parameters:
- RESET_VECTOR, 32'h80000000, PC value loaded on reset (kernel mode).
- ILLOP_VECTOR, 32'h80000004, trap target for illegal instruction or pc_src==4.
- XADR_VECTOR, 32'h80000008, trap target for interrupt or pc_src==5.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold PC; no state advance.
- pc_src  in  3  0 seq, 1 branch, 2 jump, 3 jr, 4 illop trap, 5 xadr trap, 6/7 treated as 0.
- branch_cond  in  1  branch condition (ALU result nonzero); used only when pc_src==1.
- imm16  in  16  branch offset, instruction[15:0].
- jtarget  in  26  instruction[25:0].
- jr_addr  in  32  register rs value (DataBusA).
- illegal_op  in  1  decoder flags current instruction illegal.
- irq  in  1  level interrupt request.
- pc  out  32  current fetch address.
- pc_plus4  out  32  pc+4, combinational.
- kernel  out  1  equals pc[31].
- xp_we  out  1  one-cycle write strobe to register $26.
- xp_data  out  32  exception return address.
- irq_ack  out  1  interrupt acknowledge.

Behaviour:
- Reset (sync, priority over all inputs):
  - pc=RESET_VECTOR, state=RUN, xp_we=0, xp_data=0, irq_ack=0.
  - Reset asserted mid-trap or mid-ACK_WAIT aborts it; outputs return to reset values on the next edge.
- All state updates on rising clk only.
- stall=1:
  - pc, state and irq_ack hold.
  - xp_we forced 0; xp_data holds.
  - illegal_op and irq are ignored that cycle (re-evaluated when stall drops).
- Trap priority per non-stalled cycle, highest first:
  - (a) illegal_op=1 or pc_src==4: pc<=ILLOP_VECTOR, xp_data<=pc+4.
  - (b) pc_src==5: pc<=XADR_VECTOR, xp_data<=pc+4.
  - (c) irq=1 and kernel=0 and state==RUN: pc<=XADR_VECTOR, xp_data<=pc (interrupted instruction is not retired), state<=ACK_WAIT.
  - (d) normal next-PC:
    - 0 → pc+4.
    - 1 → branch_cond ? pc+4+(sext(imm16)<<2) : pc+4.
    - 2 → {pc[31:28], jtarget, 2'b00}.
    - 3 → jr_addr with bits[1:0] forced 0.
- In every trap case (a)–(c), xp_we<=1 for exactly the following cycle, then 0.
- Arithmetic: 32-bit modulo 2^32 wraparound. Branch and jump results keep bit31 equal to current pc[31].
- Mode rules:
  - In user mode (kernel=0), jr cannot enter kernel: bit31 of the jr result forced 0.
  - In kernel mode, the jr result is taken as is; jr to an address with bit31=0 returns to user mode.
  - Trap vectors always set bit31=1.
- States: RUN, ACK_WAIT.
  - ACK_WAIT: irq_ack=1 (registered, asserted from the cycle after trap entry).
  - ACK_WAIT → RUN on the first non-stalled cycle with irq=0; irq_ack drops the same edge.
  - No new interrupt is taken in ACK_WAIT, even after returning to user mode.
  - illegal_op and pc_src 4/5 traps are still taken in ACK_WAIT.
- Simultaneous illegal_op and irq in user mode: the illop trap wins; irq stays pending and is re-evaluated the next cycle, now in kernel mode, so it is masked.
- irq in kernel mode: ignored until pc[31]=0.

Test Plan:
- Reset → pc=0x80000000, kernel=1, xp_we=0, irq_ack=0. Then 3 cycles of pc_src=0 → pc=0x8000000C.
- From pc=0x00400010:
  - branch with imm16=0xFFFF, branch_cond=1 → pc=0x00400010.
  - branch with branch_cond=0 → pc=0x00400014.
  - jump with jtarget=0x0000100 → pc=0x00000400.
- User pc=0x00400020, irq=1:
  - next pc=0x80000008; xp_we=1 for one cycle with xp_data=0x00400020; irq_ack=1 from that cycle.
  - Hold irq 5 cycles → no re-entry.
  - irq=0 → irq_ack=0 next edge.
- User pc=0x00400030 with illegal_op=1 and irq=1 together:
  - pc=0x80000004, xp_data=0x00400034.
  - Next cycle irq is masked (kernel) → pc=0x80000008 via seq.
- jr_addr=0x80001003:
  - from user pc → pc=0x00001000.
  - from kernel pc → pc=0x80001000, kernel=1.
- stall=1 for 4 cycles with irq=1 in user mode → pc unchanged, no xp_we. Then stall=0 → trap taken the same cycle.
- reset asserted in ACK_WAIT → next edge: pc=0x80000000, irq_ack=0, state RUN.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: bundles the control-side inputs and fetch-side outputs of
// the program-counter sequencer.
//   master : drives stall, pc_src, branch_cond, imm16, jtarget, jr_addr,
//            illegal_op and irq; observes pc, pc_plus4, kernel, xp_we,
//            xp_data and irq_ack.
//   slave  : the sequencer itself (mirror of master).
interface pc_sequencer_if;
  logic        stall;
  logic [2:0]  pc_src;
  logic        branch_cond;
  logic [15:0] imm16;
  logic [25:0] jtarget;
  logic [31:0] jr_addr;
  logic        illegal_op;
  logic        irq;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        kernel;
  logic        xp_we;
  logic [31:0] xp_data;
  logic        irq_ack;

  modport master (
    output stall, pc_src, branch_cond, imm16, jtarget, jr_addr, illegal_op, irq,
    input  pc, pc_plus4, kernel, xp_we, xp_data, irq_ack
  );

  modport slave (
    input  stall, pc_src, branch_cond, imm16, jtarget, jr_addr, illegal_op, irq,
    output pc, pc_plus4, kernel, xp_we, xp_data, irq_ack
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered program counter and next-PC sequencing for the
// single-cycle MIPS datapath, with stall hold, kernel/user mode (pc[31]),
// trap entry for illegal ops / explicit trap selects / interrupts, exception
// PC writeback strobe for $26, and a level-interrupt acknowledge handshake.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : pc_sequencer_if.slave (control inputs, pc / trap / ack outputs)
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h8000_0000,
  parameter logic [31:0] ILLOP_VECTOR = 32'h8000_0004,
  parameter logic [31:0] XADR_VECTOR  = 32'h8000_0008
) (
  input logic            clk,
  input logic            reset,
  pc_sequencer_if.slave  bus
);

  typedef enum logic {RUN, ACK_WAIT} state_t;

  localparam logic [2:0] SRC_BRANCH = 3'd1;
  localparam logic [2:0] SRC_JUMP   = 3'd2;
  localparam logic [2:0] SRC_JR     = 3'd3;
  localparam logic [2:0] SRC_ILLOP  = 3'd4;
  localparam logic [2:0] SRC_XADR   = 3'd5;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] xp_data_q, xp_data_d;
  logic        xp_we_q, irq_ack_q;
  logic        trap;

  logic [31:0] pc_plus4;
  logic [31:0] branch_off, branch_sum, jr_masked, seq_pc;

  assign pc_plus4   = pc_q + 32'd4;
  assign branch_off = {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
  assign branch_sum = pc_plus4 + branch_off;
  assign jr_masked  = bus.jr_addr & 32'hFFFF_FFFC;

  // Normal (non-trap) next PC. Branch and jump keep the current mode bit;
  // jr may only leave kernel mode, never enter it (pc_q[31] gates bit 31).
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    seq_pc = pc_plus4;
    case (bus.pc_src)
      SRC_BRANCH: if (bus.branch_cond)
                    seq_pc = (branch_sum & 32'h7FFF_FFFF) | {pc_q[31], 31'b0};
      SRC_JUMP:   seq_pc = {pc_q[31:28], bus.jtarget, 2'b00};
      SRC_JR:     seq_pc = {pc_q[31] & jr_masked[31], jr_masked[30:0]};
      default:    seq_pc = pc_plus4;
    endcase
  end

  // Trap priority: illegal/explicit illop, explicit xadr, then interrupt.
  // An interrupt saves pc (the instruction is not retired); the others pc+4.
  always_comb begin
    trap      = 1'b0;
    pc_d      = seq_pc;
    xp_data_d = xp_data_q;
    state_d   = state_q;
    if (bus.illegal_op || bus.pc_src == SRC_ILLOP) begin
      trap      = 1'b1;
      pc_d      = ILLOP_VECTOR;
      xp_data_d = pc_plus4;
    end else if (bus.pc_src == SRC_XADR) begin
      trap      = 1'b1;
      pc_d      = XADR_VECTOR;
      xp_data_d = pc_plus4;
    end else if (bus.irq && !pc_q[31] && state_q == RUN) begin
      trap      = 1'b1;
      pc_d      = XADR_VECTOR;
      xp_data_d = pc_q;
      state_d   = ACK_WAIT;
    end
    // Acknowledge stays up until the requester drops irq; traps taken
    // meanwhile do not disturb the handshake.
    if (state_q == ACK_WAIT && !bus.irq) state_d = RUN;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      pc_q      <= RESET_VECTOR;
      state_q   <= RUN;
      xp_we_q   <= 1'b0;
      xp_data_q <= 32'd0;
      irq_ack_q <= 1'b0;
    end else if (bus.stall) begin
      // Hold everything; the writeback strobe must not repeat while frozen.
      xp_we_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      state_q   <= state_d;
      xp_we_q   <= trap;
      xp_data_q <= xp_data_d;
      irq_ack_q <= (state_d == ACK_WAIT);
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_plus4 = pc_plus4;
  assign bus.kernel   = pc_q[31];
  assign bus.xp_we    = xp_we_q;
  assign bus.xp_data  = xp_data_q;
  assign bus.irq_ack  = irq_ack_q;

endmodule
